// File: rtl/lane_fifo_pkg.sv
// Shared definitions for the four-lane FIFO bank that sits behind the layer-1 demux.
package lane_fifo_pkg;

   localparam int NUM_LANES  = 4;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 4;

   // Pointer width; a depth of 1 would still need one bit to index storage.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so that a count of exactly DEPTH is representable.
   function automatic int cnt_w(input int depth);
      return ptr_w(depth) + 1;
   endfunction

   typedef struct packed {
      logic                  valid;
      logic [DATA_W_DEF-1:0] data;
   } lane_t;

endpackage

// File: rtl/lane_fifo.sv
// Single-lane FIFO with registered pop data, occupancy flags and a sticky
// overflow/underflow error bit.
module lane_fifo
   import lane_fifo_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int AF_THRESH = 3,
   parameter int AE_THRESH = 1
) (
   input  logic              aclk,
   input  logic              reset_L,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              err
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr_p0;
   logic [PW-1:0]     rd_ptr_p0;
   logic [CW-1:0]     count_p0;
   logic              vld_p1;
   logic [DATA_W-1:0] dout_p1;
   logic              err_p0;

   logic push_ok;
   logic pop_ok;
   logic overflow;
   logic underflow;

   // An empty FIFO never forwards the word pushed on the same edge, but a full
   // one accepts a push when a pop frees a slot on that edge.
   assign pop_ok    = pop && (count_p0 != '0);
   assign push_ok   = push && ((count_p0 != FULL_C) || pop_ok);
   assign overflow  = push && !push_ok;
   assign underflow = pop && (count_p0 == '0);

   // Storage is deliberately left out of reset.
   always_ff @(posedge aclk) begin
      if (push_ok) mem[wr_ptr_p0] <= din;
   end

   // Stage p0 -> p1: pointers, count, error and registered read port.
   always_ff @(posedge aclk) begin
      if (!reset_L) begin
         wr_ptr_p0 <= '0;
         rd_ptr_p0 <= '0;
         count_p0  <= '0;
         vld_p1    <= 1'b0;
         dout_p1   <= '0;
         err_p0    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
         if (pop_ok)  rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_p0 <= count_p0 + 1'b1;
            2'b01:   count_p0 <= count_p0 - 1'b1;
            default: count_p0 <= count_p0;
         endcase
         vld_p1  <= pop_ok;
         dout_p1 <= pop_ok ? mem[rd_ptr_p0] : '0;
         err_p0  <= err_p0 | overflow | underflow;
      end
   end

   assign valid_out    = vld_p1;
   assign data_out     = dout_p1;
   assign err          = err_p0;
   assign full         = (count_p0 == FULL_C);
   assign empty        = (count_p0 == '0);
   assign almost_full  = (count_p0 >= AF_C);
   assign almost_empty = (count_p0 <= AE_C);

endmodule

// File: rtl/lane_fifo_bank.sv
// Four independent lane FIFOs behind the layer-1 demux; this level only maps
// the flat per-lane ports onto lane_fifo instances.
module lane_fifo_bank
   import lane_fifo_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int AF_THRESH = 3,
   parameter int AE_THRESH = 1
) (
   input  logic              aclk,
   input  logic              reset_L,
   input  logic              valid_in0,
   input  logic              valid_in1,
   input  logic              valid_in2,
   input  logic              valid_in3,
   input  logic [DATA_W-1:0] data_in0,
   input  logic [DATA_W-1:0] data_in1,
   input  logic [DATA_W-1:0] data_in2,
   input  logic [DATA_W-1:0] data_in3,
   input  logic              pop0,
   input  logic              pop1,
   input  logic              pop2,
   input  logic              pop3,
   output logic              valid_out0,
   output logic              valid_out1,
   output logic              valid_out2,
   output logic              valid_out3,
   output logic [DATA_W-1:0] data_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic [DATA_W-1:0] data_out2,
   output logic [DATA_W-1:0] data_out3,
   output logic [3:0]        full,
   output logic [3:0]        empty,
   output logic [3:0]        almost_full,
   output logic [3:0]        almost_empty,
   output logic [3:0]        err
);

   logic [NUM_LANES-1:0] vin_a;
   logic [NUM_LANES-1:0] pop_a;
   logic [NUM_LANES-1:0] vout_a;
   logic [DATA_W-1:0]    din_a  [NUM_LANES];
   logic [DATA_W-1:0]    dout_a [NUM_LANES];

   assign vin_a    = {valid_in3, valid_in2, valid_in1, valid_in0};
   assign pop_a    = {pop3, pop2, pop1, pop0};
   assign din_a[0] = data_in0;
   assign din_a[1] = data_in1;
   assign din_a[2] = data_in2;
   assign din_a[3] = data_in3;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_fifo #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .AF_THRESH(AF_THRESH),
         .AE_THRESH(AE_THRESH)
      ) u_fifo (
         .aclk        (aclk),
         .reset_L     (reset_L),
         .push        (vin_a[i]),
         .din         (din_a[i]),
         .pop         (pop_a[i]),
         .valid_out   (vout_a[i]),
         .data_out    (dout_a[i]),
         .full        (full[i]),
         .empty       (empty[i]),
         .almost_full (almost_full[i]),
         .almost_empty(almost_empty[i]),
         .err         (err[i])
      );
   end

   assign valid_out0 = vout_a[0];
   assign valid_out1 = vout_a[1];
   assign valid_out2 = vout_a[2];
   assign valid_out3 = vout_a[3];
   assign data_out0  = dout_a[0];
   assign data_out1  = dout_a[1];
   assign data_out2  = dout_a[2];
   assign data_out3  = dout_a[3];

endmodule

// File: doc/lane_fifo_bank.md
Name: lane_fifo_bank

Overview:
Four-lane buffering stage directly downstream of the layer-1 demux. It captures the four demuxed byte lanes (valid + data per lane) in the aclk domain into independent per-lane FIFOs. Each lane is drained through a pop handshake by the next stage. Occupancy flags provide flow-control feedback.

Parameters:
DATA_W, 8, width of each lane's data word.
DEPTH, 4, entries per lane FIFO; must be a power of 2 and at least 2.
AF_THRESH, 3, almost_full asserts when count >= AF_THRESH.
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.

Ports:
aclk  in  1  single clock; all logic on its rising edge.
reset_L  in  1  synchronous, active-low reset.
valid_in0..valid_in3  in  1 each  push request for lane N.
data_in0..data_in3  in  DATA_W each  lane N write data.
pop0..pop3  in  1 each  read request for lane N.
valid_out0..valid_out3  out  1 each  lane N read data valid; registered.
data_out0..data_out3  out  DATA_W each  lane N read data; registered.
full  out  4  bit N = lane N count == DEPTH.
empty  out  4  bit N = lane N count == 0.
almost_full  out  4  bit N = lane N count >= AF_THRESH.
almost_empty  out  4  bit N = lane N count <= AE_THRESH.
err  out  4  bit N is a sticky overflow/underflow flag for lane N.

Behaviour:
- Reset (reset_L=0 sampled at the aclk edge): all pointers and counts are 0; valid_out*=0; data_out*=0; err=0. Flags then read full=0, empty=4'hF, almost_full=0, almost_empty=4'hF. Storage contents are not reset. Reset mid-operation discards all buffered data in the same edge.
- Lanes are fully independent; a lane's behaviour never depends on another lane.
- Push: accepted when valid_inN=1 and (count<DEPTH or a pop is accepted on the same edge). data_inN is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: accepted when popN=1 and count>0 before the edge. Data at rd_ptr is loaded into data_outN with valid_outN=1 on that edge, so read latency is 1 cycle. rd_ptr increments modulo DEPTH.
- No accepted pop on an edge: valid_outN=0 and data_outN=0 (zeroed, never held).
- Count: +1 on push only, -1 on pop only, unchanged on both or neither. Count width is clog2(DEPTH)+1.
- Simultaneous push and pop:
  - Full: both are accepted; count stays at DEPTH.
  - Empty: the pop is rejected (no fall-through bypass), the push is accepted, and the count becomes 1.
- Overflow: a push while full with no pop is dropped, storage is unchanged, and errN is set.
- Underflow: a pop while empty is ignored, valid_outN=0, and errN is set.
- errN clears only on reset.
- Flags are combinational from the registered count, so they reflect state after the last edge.
- Pointer wrap: after DEPTH pushes and pops, FIFO order is preserved across the wrap.

Decomposition:
- Shared package lane_fifo_pkg holds: NUM_LANES=4, the DATA_W/DEPTH defaults, a clog2-based pointer/count width function, and the lane_t typedef (valid + data).
- Natural sub-module: lane_fifo, a single-lane FIFO with push/pop/flags/err. lane_fifo_bank instantiates it 4 times and only does port mapping.

Test Plan:
- Reset then idle: hold reset_L=0 for 2 cycles, then release -> empty=4'hF, full=0, err=0, valid_out*=0, data_out*=0.
- Lane 0 ordering: push 8'hA1, 8'hA2, 8'hA3, then pop 3 times on consecutive cycles -> data_out0 = A1, A2, A3, each one cycle after its pop, with valid_out0=1. empty[0] returns to 1, and other lanes are untouched.
- Fill and overflow on lane 2 (DEPTH=4): push 8'h10..8'h14 -> full[2]=1 after the 4th push, 8'h14 is dropped, err[2]=1. Draining yields 10, 11, 12, 13.
- Full with simultaneous push and pop on lane 1: lane full with 20..23; assert pop1 and push 8'h24 together -> data_out1=20, full[1] stays 1, err[1]=0. Subsequent drain yields 21..24.
- Empty with simultaneous push and pop plus underflow on lane 3:
  - Push 8'h55 with pop3=1 while empty -> valid_out3=0, count=1, err[3]=1.
  - Next pop -> data_out3=8'h55.
- Wrap and parallel lanes: run 10 push/pop pairs on all lanes concurrently with distinct data -> in-order output per lane across the pointer wrap. almost_full and almost_empty track counts 3 and 1 exactly.
